// File: rtl/rst_seq_sync_pkg.sv
// ============================================================================
// Module   : rst_seq_sync_pkg
// Brief    : Shared types, limits and sizing helper for the reset sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package rst_seq_sync_pkg;

    typedef enum logic [1:0] {
        ASSERT  = 2'd0,
        HOLD    = 2'd1,
        RELEASE = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam int NUM_OUT_MIN     = 1;
    localparam int NUM_OUT_MAX     = 16;
    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 4;
    localparam int CYCLES_MAX      = 1023;

    // Wide enough for the larger of the hold and gap terminal counts, never zero.
    function automatic int cnt_width(input int hold, input int gap);
        int m;
        int w;
        m = (hold > gap) ? hold : gap;
        w = $clog2(m + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rst_sync_chain.sv
// ============================================================================
// Module   : rst_sync_chain
// Brief    : N-flop reset synchroniser, asynchronous assert / synchronous release.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rst_sync_chain #(
    parameter int STAGES = 2
) (
    input  logic CLK,
    input  logic RST,
    output logic SYNC_OUT
);

    logic [STAGES-1:0] chain_q;
    logic [STAGES-1:0] chain_d;

    always_comb begin
        chain_d = {chain_q[STAGES-2:0], 1'b1};
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            chain_q <= '0;
        end else begin
            chain_q <= chain_d;
        end
    end

    assign SYNC_OUT = chain_q[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/rst_seq_sync.sv
// ============================================================================
// Module   : rst_seq_sync
// Brief    : Reset synchroniser plus ordered release of NUM_OUT reset outputs.
//            Software reset request enabled by macro RST_SEQ_SYNC_SWRST_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rst_seq_sync
    import rst_seq_sync_pkg::*;
#(
    parameter int NUM_OUT     = 3,
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 3
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               SW_RST_REQ,
    output logic [NUM_OUT-1:0] SYNC_RST,
    output logic               RST_DONE
);

    localparam int CNT_W = cnt_width(HOLD_CYCLES, GAP_CYCLES);
    localparam int IDX_W = $clog2(NUM_OUT + 1);

    localparam logic [CNT_W-1:0] C_HOLD_LAST = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] C_GAP_LAST  = CNT_W'(GAP_CYCLES);
    localparam logic [IDX_W-1:0] C_IDX_LAST  = IDX_W'(NUM_OUT - 1);

    if (NUM_OUT < NUM_OUT_MIN || NUM_OUT > NUM_OUT_MAX ||
        SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX ||
        HOLD_CYCLES < 0 || HOLD_CYCLES > CYCLES_MAX ||
        GAP_CYCLES < 0 || GAP_CYCLES > CYCLES_MAX) begin : g_param_check
        $error("rst_seq_sync: parameter out of range");
    end

    logic               sync_q;
    logic               sw_req;
    state_t             state_q,    state_d;
    logic [CNT_W-1:0]   cnt_q,      cnt_d;
    logic [IDX_W-1:0]   idx_q,      idx_d;
    logic [NUM_OUT-1:0] sync_rst_q, sync_rst_d;
    logic               rst_done_q, rst_done_d;

    rst_sync_chain #(
        .STAGES   (SYNC_STAGES)
    ) u_sync_chain (
        .CLK      (CLK),
        .RST      (RST),
        .SYNC_OUT (sync_q)
    );

`ifdef RST_SEQ_SYNC_SWRST_EN
    assign sw_req = SW_RST_REQ;
`else
    logic unused_sw_rst_req;
    assign unused_sw_rst_req = SW_RST_REQ;
    assign sw_req            = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        sync_rst_d = sync_rst_q;
        rst_done_d = rst_done_q;

        case (state_q)
            ASSERT: begin
                sync_rst_d = '0;
                rst_done_d = 1'b0;
                cnt_d      = '0;
                idx_d      = '0;
                if (sync_q) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (cnt_q == C_HOLD_LAST) begin
                    sync_rst_d = NUM_OUT'(1);
                    cnt_d      = '0;
                    if (NUM_OUT == 1) begin
                        state_d    = DONE;
                        rst_done_d = 1'b1;
                    end else begin
                        state_d = RELEASE;
                        idx_d   = IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RELEASE: begin
                if (cnt_q == C_GAP_LAST) begin
                    sync_rst_d = sync_rst_q | (NUM_OUT'(1) << idx_q);
                    cnt_d      = '0;
                    if (idx_q == C_IDX_LAST) begin
                        state_d    = DONE;
                        rst_done_d = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
            end
            default: begin
                state_d = ASSERT;
            end
        endcase

        // A software request outranks any release due on the same edge.
        if (sw_req && (state_q != ASSERT)) begin
            state_d    = HOLD;
            cnt_d      = '0;
            idx_d      = '0;
            sync_rst_d = '0;
            rst_done_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= ASSERT;
            cnt_q      <= '0;
            idx_q      <= '0;
            sync_rst_q <= '0;
            rst_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            sync_rst_q <= sync_rst_d;
            rst_done_q <= rst_done_d;
        end
    end

    assign SYNC_RST = sync_rst_q;
    assign RST_DONE = rst_done_q;

endmodule

`default_nettype wire

// File: tb/tb_rst_seq_sync.sv
// ============================================================================
// Module   : tb_rst_seq_sync
// Brief    : Self-checking bench for rst_seq_sync against an edge-count model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_rst_seq_sync;

    localparam int N_A = 3, S_A = 2, H_A = 4, G_A = 3;
    localparam int N_B = 4, S_B = 2, H_B = 0, G_B = 0;

`ifdef RST_SEQ_SYNC_SWRST_EN
    localparam bit SW_EN = 1'b1;
`else
    localparam bit SW_EN = 1'b0;
`endif

    logic           CLK        = 1'b0;
    logic           RST        = 1'b1;
    logic           SW_RST_REQ = 1'b0;
    logic [N_A-1:0] sync_rst_a;
    logic           done_a;
    logic [N_B-1:0] sync_rst_b;
    logic           done_b;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: edges seen with RST high since the last reset, and the edge of
    // the most recent accepted software request (-1 = none) per instance.
    int edge_n = 0;
    int k_a    = -1;
    int k_b    = -1;

    always #5 CLK = ~CLK;

    rst_seq_sync #(
        .NUM_OUT     (N_A),
        .SYNC_STAGES (S_A),
        .HOLD_CYCLES (H_A),
        .GAP_CYCLES  (G_A)
    ) dut_a (
        .CLK        (CLK),
        .RST        (RST),
        .SW_RST_REQ (SW_RST_REQ),
        .SYNC_RST   (sync_rst_a),
        .RST_DONE   (done_a)
    );

    rst_seq_sync #(
        .NUM_OUT     (N_B),
        .SYNC_STAGES (S_B),
        .HOLD_CYCLES (H_B),
        .GAP_CYCLES  (G_B)
    ) dut_b (
        .CLK        (CLK),
        .RST        (RST),
        .SW_RST_REQ (SW_RST_REQ),
        .SYNC_RST   (sync_rst_b),
        .RST_DONE   (done_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s @edge %0d: got 0x%0h, expected 0x%0h", tag, edge_n, obs, exp);
        end
    endtask

    // Bit i is released once the edge count reaches the sequence start plus i gaps.
    function automatic logic [15:0] exp_vec(input int n, input int k, input int s,
                                            input int h, input int g, input int num);
        logic [15:0] v;
        int          base;
        v = '0;
        if (n == 0) return v;
        base = (k >= 0) ? (k + h + 1) : (s + h + 2);
        for (int i = 0; i < num; i++) begin
            if (n >= base + (g + 1) * i) v[i] = 1'b1;
        end
        return v;
    endfunction

    task automatic check_outputs(input string tag);
        logic [15:0] ea;
        logic [15:0] eb;
        ea = exp_vec(edge_n, k_a, S_A, H_A, G_A, N_A);
        eb = exp_vec(edge_n, k_b, S_B, H_B, G_B, N_B);
        check({tag, "_a_vec"},  32'(sync_rst_a), 32'(ea[N_A-1:0]));
        check({tag, "_a_done"}, 32'(done_a),     32'(ea[N_A-1:0] == {N_A{1'b1}}));
        check({tag, "_b_vec"},  32'(sync_rst_b), 32'(eb[N_B-1:0]));
        check({tag, "_b_done"}, 32'(done_b),     32'(eb[N_B-1:0] == {N_B{1'b1}}));
    endtask

    task automatic model_reset();
        edge_n = 0;
        k_a    = -1;
        k_b    = -1;
    endtask

    task automatic step(input string tag);
        @(posedge CLK);
        if (RST) begin
            edge_n++;
            if (SW_EN && SW_RST_REQ) begin
                if (edge_n > S_A + 1) k_a = edge_n;
                if (edge_n > S_B + 1) k_b = edge_n;
            end
        end
        #1;
        check_outputs(tag);
    endtask

    task automatic glitch();
        RST = 1'b0;
        #1;
        model_reset();
        check_outputs("glitch");
        RST = 1'b1;
    endtask

    initial begin
        #2;
        RST = 1'b0;
        model_reset();
        repeat (3) step("rst_low");

        RST = 1'b1;
        repeat (13) step("por");
        check("por_a_mid", 32'(sync_rst_a), 32'h3);
        check("por_b_all", 32'(sync_rst_b), 32'hF);

        // Sub-cycle RST pulse mid-release, then the restarted sequence with
        // software pulses at edges 10, 13 and 100 of the new epoch.
        glitch();
        while (edge_n < 130) begin
            SW_RST_REQ = ((edge_n + 1) == 10) || ((edge_n + 1) == 13) || ((edge_n + 1) == 100);
            step("seq");
        end
        SW_RST_REQ = 1'b0;

        for (int c = 0; c < 800; c++) begin
            int r;
            SW_RST_REQ = ($urandom_range(0, 5) == 0);
            r = $urandom_range(0, 99);
            if (r == 0 && RST) begin
                glitch();
            end else if (r == 1) begin
                RST = 1'b0;
                #1;
                model_reset();
                check_outputs("rst_drop");
            end else if (!RST && r < 40) begin
                RST = 1'b1;
            end
            step("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
